// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory-port arbiter.
// Provides the sequencer state type, default widths and the op encoding
// used on req_store (OP_LOAD / OP_STORE).
package mem_arb_pkg;

    localparam int unsigned DEF_NUM_REQ = 2;
    localparam int unsigned DEF_ADDR_W  = 32;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_TIMEOUT = 255;
    localparam int unsigned DEF_CNT_W   = 8;

    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_STORE = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker, reusable by any shared-port controller.
// Ports:
//   req  - request vector, one bit per requester
//   last - index of the previously served requester
//   gnt  - one-hot grant (all zero when nothing is requested)
//   idx  - binary index of the granted requester
//   any  - at least one request is pending
module rr_pick #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int unsigned pos;

    // Scan last+1 .. last+N modulo N; first set bit wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            pos = (32'(last) + k) % N;
            if (!any && req[IW'(pos)]) begin
                any            = 1'b1;
                gnt[IW'(pos)]  = 1'b1;
                idx            = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and transaction sequencer for the shared LOAD/STORE port.
// Ports:
//   CLK, RST                      - clock, asynchronous active-high reset
//   req_valid/req_store           - per-requester request and op (1 = store)
//   req_addr/req_wdata            - packed per-requester address / store data
//   req_ready                     - one-hot accept pulse (combinational in IDLE)
//   resp_valid/resp_err/resp_rdata- one-hot completion pulse, timeout flag, load data
//   mem_addr/mem_wdata            - latched command to the memory subsystem
//   LOAD/STORE/VALID, READY       - command strobes and handshake
//   mem_done/mem_rdata            - completion pulse and load data from memory
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_store,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic                      resp_err,
    output logic [DATA_W-1:0]         resp_rdata,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic                      LOAD,
    output logic                      STORE,
    output logic                      VALID,
    input  logic                      READY,
    input  logic                      mem_done,
    input  logic [DATA_W-1:0]         mem_rdata
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    state_t             state;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   cur_grant;
    logic               op;
    logic [CNT_W-1:0]   cnt;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

    logic [CNT_W-1:0]   cnt_inc;
    logic               active;
    logic               complete;
    logic               timed_out;

    // Unpack the per-requester buses.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
        assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
    end

    rr_pick #(
        .N (NUM_REQ),
        .IW(IDX_W)
    ) u_rr_pick (
        .req (req_valid),
        .last(last_grant),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Accept pulse comes straight from arbitration; forced low during reset.
    assign req_ready = (state == IDLE && !RST) ? pick_gnt : '0;

    // Completion needs READY in ISSUE (mem_done alone is ignored there);
    // a completion in the expiry cycle beats the timeout.
    assign cnt_inc   = cnt + CNT_W'(1);
    assign active    = (state == ISSUE) || (state == WAIT);
    assign complete  = active && mem_done && ((state == WAIT) || READY);
    assign timed_out = active && !complete && (cnt_inc == CNT_W'(TIMEOUT));

    // Sequencer: arbitration, command issue, completion/timeout, response.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            last_grant <= IDX_W'(NUM_REQ - 1);
            cur_grant  <= '0;
            op         <= OP_LOAD;
            cnt        <= '0;
            resp_valid <= '0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            LOAD       <= 1'b0;
            STORE      <= 1'b0;
            VALID      <= 1'b0;
        end else begin
            resp_valid <= '0;
            case (state)
                IDLE: begin
                    resp_err <= 1'b0;
                    if (pick_any) begin
                        cur_grant <= pick_idx;
                        op        <= req_store[pick_idx];
                        mem_addr  <= addr_arr[pick_idx];
                        mem_wdata <= wdata_arr[pick_idx];
                        cnt       <= '0;
                        VALID     <= 1'b1;
                        LOAD      <= (req_store[pick_idx] == OP_LOAD);
                        STORE     <= (req_store[pick_idx] == OP_STORE);
                        state     <= ISSUE;
                    end
                end
                ISSUE, WAIT: begin
                    cnt <= cnt_inc;
                    if (complete || timed_out) begin
                        VALID      <= 1'b0;
                        LOAD       <= 1'b0;
                        STORE      <= 1'b0;
                        resp_valid <= NUM_REQ'(1) << cur_grant;
                        resp_err   <= timed_out;
                        if (timed_out) begin
                            resp_rdata <= '0;
                        end else if (op == OP_LOAD) begin
                            resp_rdata <= mem_rdata;
                        end
                        state <= RESP;
                    end else if (state == ISSUE && READY) begin
                        VALID <= 1'b0;
                        LOAD  <= 1'b0;
                        STORE <= 1'b0;
                        state <= WAIT;
                    end
                end
                RESP: begin
                    last_grant <= cur_grant;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// transactions compared against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam int CW = 8;

    logic            CLK = 1'b0;
    logic            RST;
    logic [N-1:0]    req_valid, req_store, req_ready, resp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic            resp_err, LOAD, STORE, VALID, READY, mem_done;
    logic [DW-1:0]   resp_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]   mem_addr;

    int total = 0;
    int bad   = 0;

    // Reference model state: previous winner and last returned read data.
    int            m_last;
    logic [DW-1:0] m_prev;

    typedef struct {
        logic [N-1:0]  ready, resp, after;
        logic          err, ld, st;
        logic [DW-1:0] rdata, wdata;
        logic [AW-1:0] addr;
        int            lat, vcyc;
        bit            unstable;
    } obs_t;

    typedef struct {
        logic [N-1:0]  grant;
        logic          err, ld, st;
        logic [DW-1:0] rdata, wdata;
        logic [AW-1:0] addr;
        int            lat, vcyc;
    } exp_t;

    mem_port_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_store(req_store),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .LOAD(LOAD), .STORE(STORE), .VALID(VALID), .READY(READY),
        .mem_done(mem_done), .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Transaction-level expectation: who wins, when it completes, what returns.
    // rdel = ISSUE cycles with READY low; dd = cycles from READY to mem_done (-1 = never).
    function automatic exp_t model_txn(input logic [N-1:0] rv, input logic [N-1:0] rs,
                                       input logic [N*AW-1:0] a, input logic [N*DW-1:0] w,
                                       input int rdel, input int dd, input logic [DW-1:0] rd);
        exp_t e;
        int g, j, r, kd, ev;
        g = -1;
        for (int k = 1; k <= N; k++) begin
            j = (m_last + k) % N;
            if (g < 0 && 1'(rv >> j)) g = j;
        end
        e.grant = (g < 0) ? '0 : (N'(1) << g);
        if (g < 0) g = 0;
        e.st    = 1'(rs >> g);
        e.ld    = !e.st;
        e.addr  = AW'(a >> (g * AW));
        e.wdata = DW'(w >> (g * DW));
        r  = 1 + rdel;
        kd = (dd >= 0) ? r + dd : -1;
        if (kd >= 0 && kd <= TO) begin
            e.err = 1'b0;
            ev    = kd;
        end else begin
            e.err = 1'b1;
            ev    = TO;
        end
        e.lat   = ev + 1;
        e.vcyc  = (r < ev) ? r : ev;
        e.rdata = e.err ? '0 : (e.st ? m_prev : rd);
        if (e.grant != '0) begin
            m_last = g;
            m_prev = e.rdata;
        end
        return e;
    endfunction

    // Drives one transaction starting from IDLE and records what the DUT did.
    task automatic do_txn(input logic [N-1:0] rv, input logic [N-1:0] rs,
                          input logic [N*AW-1:0] a, input logic [N*DW-1:0] w,
                          input int rdel, input int dd, input logic [DW-1:0] rd,
                          input bit noise, output obs_t o);
        int r, kd;
        r  = 1 + rdel;
        kd = (dd >= 0) ? r + dd : -1;
        o.lat = -1; o.vcyc = 0; o.unstable = 1'b0; o.resp = '0; o.err = 1'bx;
        o.rdata = 'x; o.addr = 'x; o.wdata = 'x; o.ld = 1'bx; o.st = 1'bx;
        req_valid = rv; req_store = rs; req_addr = a; req_wdata = w;
        READY = 1'b0; mem_done = 1'b0;
        @(negedge CLK);
        o.ready = req_ready;
        @(posedge CLK); #1;
        // Scramble requester fields to prove the command was latched.
        req_valid = '0; req_store = N'($urandom);
        req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
        for (int k = 1; k <= 40 && o.lat < 0; k++) begin
            READY     = (k == r) ? 1'b1 : ((noise && k > r) ? 1'($urandom) : 1'b0);
            mem_done  = (k == kd) ? 1'b1 : ((noise && k < r) ? 1'($urandom) : 1'b0);
            mem_rdata = (k == kd) ? rd : $urandom;
            @(negedge CLK);
            if (VALID === 1'b1) begin
                if (o.vcyc == 0) begin
                    o.addr = mem_addr; o.wdata = mem_wdata; o.ld = LOAD; o.st = STORE;
                end else if (mem_addr !== o.addr || mem_wdata !== o.wdata ||
                             LOAD !== o.ld || STORE !== o.st) begin
                    o.unstable = 1'b1;
                end
                o.vcyc++;
            end
            if (resp_valid !== '0) begin
                o.resp = resp_valid; o.err = resp_err; o.rdata = resp_rdata; o.lat = k;
            end
            @(posedge CLK); #1;
        end
        READY = 1'b0; mem_done = 1'b0;
        @(negedge CLK);
        o.after = resp_valid;
        @(posedge CLK); #1;
    endtask

    task automatic apply_reset();
        RST = 1'b1; req_valid = '0; req_store = '0; req_addr = '0; req_wdata = '0;
        READY = 1'b0; mem_done = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge CLK);
        #1; RST = 1'b0;
        m_last = N - 1; m_prev = '0;
    endtask

    task automatic test_reset();
        RST = 1'b1; req_valid = '1; req_store = '0; req_addr = '1; req_wdata = '1;
        READY = 1'b1; mem_done = 1'b1; mem_rdata = '1;
        @(posedge CLK); #1;
        total++;
        if (req_ready !== '0) begin
            bad++; $display("FAIL reset_req_ready: got=%b want=0", req_ready);
        end
        total++;
        if ({VALID, LOAD, STORE, resp_valid, resp_err, mem_addr, mem_wdata, resp_rdata} !== '0) begin
            bad++; $display("FAIL reset_outputs: got VALID=%b LOAD=%b STORE=%b resp_valid=%b err=%b addr=%h wdata=%h rdata=%h want all 0",
                            VALID, LOAD, STORE, resp_valid, resp_err, mem_addr, mem_wdata, resp_rdata);
        end
        apply_reset();
        @(negedge CLK);
        total++;
        if (VALID !== 1'b0 || req_ready !== '0 || resp_valid !== '0) begin
            bad++; $display("FAIL reset_idle_quiet: got VALID=%b req_ready=%b resp_valid=%b want 0",
                            VALID, req_ready, resp_valid);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_single_load();
        obs_t o; exp_t e;
        logic [N*AW-1:0] a; logic [N*DW-1:0] w;
        a = {32'h0000_0000, 32'h0000_0100}; w = {$urandom, $urandom};
        e = model_txn(2'b01, 2'b00, a, w, 0, 1, 32'hDEAD_BEEF);
        do_txn(2'b01, 2'b00, a, w, 0, 1, 32'hDEAD_BEEF, 1'b0, o);
        total++;
        if (o.ready !== 2'b01) begin bad++; $display("FAIL load_ready: got=%b want=01", o.ready); end
        total++;
        if (o.ld !== 1'b1 || o.st !== 1'b0 || o.addr !== 32'h100) begin
            bad++; $display("FAIL load_cmd: got LOAD=%b STORE=%b addr=%h want 1 0 00000100", o.ld, o.st, o.addr);
        end
        total++;
        if (o.resp !== 2'b01 || o.lat !== 3) begin
            bad++; $display("FAIL load_resp: got resp=%b lat=%0d want 01 lat=3", o.resp, o.lat);
        end
        total++;
        if (o.err !== 1'b0 || o.rdata !== e.rdata) begin
            bad++; $display("FAIL load_data: got err=%b rdata=%h want 0 %h", o.err, o.rdata, e.rdata);
        end
        total++;
        if (o.after !== '0) begin bad++; $display("FAIL load_pulse: got=%b want=00", o.after); end
    endtask

    task automatic test_round_robin();
        obs_t o; exp_t e;
        logic [N-1:0] prev;
        prev = '0;
        for (int t = 0; t < 4; t++) begin
            logic [N*AW-1:0] a; logic [N*DW-1:0] w; logic [DW-1:0] rd;
            a = {$urandom, $urandom}; w = {$urandom, $urandom}; rd = $urandom;
            e = model_txn('1, 2'b00, a, w, 0, 1, rd);
            do_txn('1, 2'b00, a, w, 0, 1, rd, 1'b0, o);
            total++;
            if (o.ready !== e.grant || o.ready === prev) begin
                bad++; $display("FAIL rr_grant[%0d]: got=%b want=%b prev=%b", t, o.ready, e.grant, prev);
            end
            total++;
            if (o.resp !== e.grant) begin
                bad++; $display("FAIL rr_resp[%0d]: got=%b want=%b", t, o.resp, e.grant);
            end
            prev = o.ready;
        end
    endtask

    task automatic test_store_backpressure();
        obs_t o; exp_t e;
        logic [N*AW-1:0] a; logic [N*DW-1:0] w;
        a = {32'h0000_0020, $urandom}; w = {32'h0000_0055, $urandom};
        e = model_txn(2'b10, 2'b10, a, w, 5, 2, 32'h1234_5678);
        do_txn(2'b10, 2'b10, a, w, 5, 2, 32'h1234_5678, 1'b1, o);
        total++;
        if (o.vcyc !== 6 || o.unstable !== 1'b0) begin
            bad++; $display("FAIL store_hold: got valid_cycles=%0d unstable=%b want 6 0", o.vcyc, o.unstable);
        end
        total++;
        if (o.st !== 1'b1 || o.ld !== 1'b0 || o.addr !== 32'h20 || o.wdata !== 32'h55) begin
            bad++; $display("FAIL store_cmd: got STORE=%b LOAD=%b addr=%h wdata=%h want 1 0 20 55",
                            o.st, o.ld, o.addr, o.wdata);
        end
        total++;
        if (o.resp !== 2'b10 || o.err !== 1'b0 || o.rdata !== e.rdata || o.lat !== e.lat) begin
            bad++; $display("FAIL store_resp: got resp=%b err=%b rdata=%h lat=%0d want 10 0 %h %0d",
                            o.resp, o.err, o.rdata, o.lat, e.rdata, e.lat);
        end
    endtask

    task automatic test_timeout();
        obs_t o; exp_t e;
        logic [N*AW-1:0] a; logic [N*DW-1:0] w;
        a = {$urandom, $urandom}; w = {$urandom, $urandom};
        e = model_txn(2'b01, 2'b00, a, w, 0, -1, 32'h0);
        do_txn(2'b01, 2'b00, a, w, 0, -1, 32'h0, 1'b0, o);
        total++;
        if (o.resp !== 2'b01 || o.err !== 1'b1 || o.rdata !== '0 || o.lat !== TO + 1) begin
            bad++; $display("FAIL timeout: got resp=%b err=%b rdata=%h lat=%0d want 01 1 0 %0d",
                            o.resp, o.err, o.rdata, o.lat, TO + 1);
        end
        e = model_txn(2'b01, 2'b00, a, w, 1, 1, 32'hA5A5_0001);
        do_txn(2'b01, 2'b00, a, w, 1, 1, 32'hA5A5_0001, 1'b0, o);
        total++;
        if (o.ready !== 2'b01 || o.err !== 1'b0 || o.rdata !== 32'hA5A5_0001 || o.lat !== e.lat) begin
            bad++; $display("FAIL after_timeout: got ready=%b err=%b rdata=%h lat=%0d want 01 0 a5a50001 %0d",
                            o.ready, o.err, o.rdata, o.lat, e.lat);
        end
    endtask

    task automatic test_boundaries();
        obs_t o; exp_t e;
        logic [N*AW-1:0] a; logic [N*DW-1:0] w;
        a = {$urandom, $urandom}; w = {$urandom, $urandom};
        // mem_done lands exactly in the expiry cycle
        e = model_txn(2'b01, 2'b00, a, w, 0, TO - 1, 32'h0BAD_CAFE);
        do_txn(2'b01, 2'b00, a, w, 0, TO - 1, 32'h0BAD_CAFE, 1'b0, o);
        total++;
        if (o.err !== 1'b0 || o.rdata !== 32'h0BAD_CAFE || o.lat !== TO + 1) begin
            bad++; $display("FAIL done_at_timeout: got err=%b rdata=%h lat=%0d want 0 0badcafe %0d",
                            o.err, o.rdata, o.lat, TO + 1);
        end
        // mem_done one cycle too late
        e = model_txn(2'b01, 2'b00, a, w, 0, TO, 32'h7777_7777);
        do_txn(2'b01, 2'b00, a, w, 0, TO, 32'h7777_7777, 1'b0, o);
        total++;
        if (o.err !== 1'b1 || o.rdata !== '0 || o.lat !== TO + 1) begin
            bad++; $display("FAIL done_after_timeout: got err=%b rdata=%h lat=%0d want 1 0 %0d",
                            o.err, o.rdata, o.lat, TO + 1);
        end
        // READY and mem_done together in ISSUE
        e = model_txn(2'b01, 2'b00, a, w, 0, 0, 32'h1357_9BDF);
        do_txn(2'b01, 2'b00, a, w, 0, 0, 32'h1357_9BDF, 1'b0, o);
        total++;
        if (o.lat !== 2 || o.err !== 1'b0 || o.rdata !== 32'h1357_9BDF) begin
            bad++; $display("FAIL ready_done_same: got lat=%0d err=%b rdata=%h want 2 0 13579bdf",
                            o.lat, o.err, o.rdata);
        end
    endtask

    task automatic test_random();
        obs_t o; exp_t e;
        for (int t = 0; t < 30; t++) begin
            logic [N-1:0] rv, rs; logic [N*AW-1:0] a; logic [N*DW-1:0] w;
            logic [DW-1:0] rd; int rdel, dd;
            rv   = N'($urandom_range(1, (1 << N) - 1));
            rs   = N'($urandom);
            a    = {$urandom, $urandom};
            w    = {$urandom, $urandom};
            rd   = $urandom;
            rdel = int'($urandom_range(0, 4));
            dd   = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 9));
            e = model_txn(rv, rs, a, w, rdel, dd, rd);
            do_txn(rv, rs, a, w, rdel, dd, rd, 1'b1, o);
            total++;
            if (o.ready !== e.grant || o.resp !== e.grant || o.after !== '0) begin
                bad++; $display("FAIL rnd_grant[%0d]: got ready=%b resp=%b after=%b want %b %b 00",
                                t, o.ready, o.resp, o.after, e.grant, e.grant);
            end
            total++;
            if (o.lat !== e.lat || o.err !== e.err || o.rdata !== e.rdata) begin
                bad++; $display("FAIL rnd_resp[%0d]: got lat=%0d err=%b rdata=%h want %0d %b %h",
                                t, o.lat, o.err, o.rdata, e.lat, e.err, e.rdata);
            end
            total++;
            if (o.vcyc !== e.vcyc || o.unstable !== 1'b0 || o.addr !== e.addr ||
                o.wdata !== e.wdata || o.ld !== e.ld || o.st !== e.st) begin
                bad++; $display("FAIL rnd_cmd[%0d]: got vc=%0d unst=%b addr=%h wd=%h ld=%b st=%b want %0d 0 %h %h %b %b",
                                t, o.vcyc, o.unstable, o.addr, o.wdata, o.ld, o.st,
                                e.vcyc, e.addr, e.wdata, e.ld, e.st);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        obs_t o; exp_t e;
        logic [N*AW-1:0] a; logic [N*DW-1:0] w;
        a = {$urandom, 32'h0000_0400}; w = {$urandom, $urandom};
        // Leave requester 0 as the last winner so a correct reset must flip priority back.
        e = model_txn(2'b01, 2'b00, a, w, 0, 1, 32'hCAFE_F00D);
        do_txn(2'b01, 2'b00, a, w, 0, 1, 32'hCAFE_F00D, 1'b0, o);
        total++;
        if (o.ready !== e.grant) begin
            bad++; $display("FAIL mid_wait_setup: got=%b want=%b", o.ready, e.grant);
        end
        req_valid = 2'b01; req_store = '0; req_addr = {32'h0, 32'h0000_0ABC};
        @(negedge CLK);
        total++;
        if (req_ready !== 2'b01) begin
            bad++; $display("FAIL mid_wait_accept: got=%b want=01", req_ready);
        end
        @(posedge CLK); #1;
        req_valid = '0; READY = 1'b1;
        @(posedge CLK); #1;
        READY = 1'b0;
        #2; RST = 1'b1; #1;
        total++;
        if ({VALID, LOAD, STORE, resp_valid, resp_err, mem_addr, mem_wdata, resp_rdata, req_ready} !== '0) begin
            bad++; $display("FAIL async_reset: got VALID=%b resp_valid=%b addr=%h wdata=%h rdata=%h want all 0",
                            VALID, resp_valid, mem_addr, mem_wdata, resp_rdata);
        end
        @(posedge CLK); #1;
        RST = 1'b0; m_last = N - 1; m_prev = '0;
        for (int k = 0; k < 3; k++) begin
            mem_done = 1'b1;
            @(negedge CLK);
            total++;
            if (resp_valid !== '0 || VALID !== 1'b0) begin
                bad++; $display("FAIL no_resp_after_reset[%0d]: got resp_valid=%b VALID=%b want 0",
                                k, resp_valid, VALID);
            end
            @(posedge CLK); #1;
        end
        mem_done = 1'b0;
        e = model_txn('1, 2'b00, a, w, 0, 1, 32'h0F0F_0F0F);
        do_txn('1, 2'b00, a, w, 0, 1, 32'h0F0F_0F0F, 1'b0, o);
        total++;
        if (o.ready !== e.grant || o.rdata !== e.rdata) begin
            bad++; $display("FAIL first_after_reset: got ready=%b rdata=%h want %b %h",
                            o.ready, o.rdata, e.grant, e.rdata);
        end
    endtask

    initial begin
        m_last = N - 1; m_prev = '0;
        test_reset();
        test_single_load();
        test_round_robin();
        test_store_backpressure();
        test_timeout();
        test_boundaries();
        test_random();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
